uart_tx_arb: RTL and testbench

- Shares the single UART transmit path between NUM_REQ byte-stream requesters, e.g. the rx echo path, a status reporter and a command responder.
- Each requester is granted for one whole packet, ending on the byte flagged last. Grants rotate round-robin.
- Sits between the requesters and the uart_tx character FIFO write port, in the clk_tx domain.
- A watchdog releases the grant if the granted requester stalls mid-packet.

---
 rtl/uart_tx_arb_pkg.sv | 13 +
 rtl/uart_tx_arb_rr_pick.sv | 44 ++++
 rtl/uart_tx_arb.sv | 121 ++++++++++++
 tb/tb_uart_tx_arb.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_tx_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      XFER = 1'b1
   } state_t;

   localparam int unsigned BYTE_W  = 8;
   localparam int unsigned GNT_W   = 3;
   localparam int unsigned MAX_REQ = 8;

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational rotate-priority picker: first requester after last_gnt, with wrap.
// Optional macro UART_TX_ARB_PRIO_EN: requester 0 wins whenever it requests.
module uart_tx_arb_rr_pick
   import uart_tx_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 3
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [GNT_W-1:0]   last_gnt,
   output logic [GNT_W-1:0]   pick,
   output logic               any_req
);

   localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   int unsigned idx;
   logic        found;

   // Scan offsets 1..NUM_REQ from the last grant; last_gnt < NUM_REQ so one wrap suffices.
   always_comb begin
      pick  = last_gnt;
      found = 1'b0;
      idx   = 0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         idx = 32'(last_gnt) + k;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         if (!found && req[IW'(idx)]) begin
            pick  = GNT_W'(idx);
            found = 1'b1;
         end
      end
`ifdef UART_TX_ARB_PRIO_EN
      // Requester 0 overrides the rotation; the others still rotate among themselves.
      if (req[0]) begin
         pick = '0;
      end
`endif
   end

   assign any_req = |req;

endmodule

// File: rtl/uart_tx_arb.sv
// Packet-locked round-robin arbiter in front of the uart_tx character FIFO write port.
// A grant lasts one packet (up to req_last); a watchdog frees a grant whose owner stalls.
// Optional macro UART_TX_ARB_PRIO_EN gives requester 0 strict priority in arbitration.
module uart_tx_arb
   import uart_tx_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ     = 3,
   parameter int unsigned TIMEOUT_CYC = 65535,
   parameter int unsigned CNT_W       = 16
) (
   input  logic                      clk_tx,
   input  logic                      rst_clk_tx_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [BYTE_W*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]        req_last,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic                      tx_full,
   output logic [BYTE_W-1:0]         tx_data,
   output logic                      tx_wr_en,
   output logic [GNT_W-1:0]          grant_id,
   output logic                      busy,
   output logic                      timeout_err
);

   localparam int unsigned IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam bit          WD_EN   = (TIMEOUT_CYC != 0);
   localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYC - 1);

   state_t             state;
   state_t             state_nxt;
   logic [GNT_W-1:0]   grant_nxt;
   logic [GNT_W-1:0]   pick;
   logic               any_req;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cnt_nxt;
   logic               tout_nxt;
   logic [IW-1:0]      gsel;
   logic               g_valid;
   logic               g_last;
   logic [BYTE_W-1:0]  data_arr [NUM_REQ];

   // Split the flat data bus into per-requester bytes.
   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign data_arr[i] = req_data[BYTE_W*i +: BYTE_W];
   end

   assign gsel    = grant_id[IW-1:0];
   assign g_valid = req_valid[gsel];
   assign g_last  = req_last[gsel];
   assign busy    = (state == XFER);

   // Next grantee chosen from the current grant_id.
   uart_tx_arb_rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_pick (
      .req      (req_valid),
      .last_gnt (grant_id),
      .pick     (pick),
      .any_req  (any_req)
   );

   // State, grant, watchdog counter and timeout pulse registers.
   always_ff @(posedge clk_tx or negedge rst_clk_tx_n) begin
      if (!rst_clk_tx_n) begin
         state       <= IDLE;
         grant_id    <= GNT_W'(NUM_REQ - 1);
         cnt         <= '0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_nxt;
         grant_id    <= grant_nxt;
         cnt         <= cnt_nxt;
         timeout_err <= tout_nxt;
      end
   end

   // Arbitration, packet transfer and watchdog; FIFO-side strobes are combinational.
   always_comb begin
      state_nxt = state;
      grant_nxt = grant_id;
      cnt_nxt   = cnt;
      tout_nxt  = 1'b0;
      req_ready = '0;
      tx_wr_en  = 1'b0;
      tx_data   = '0;
      case (state)
         IDLE: begin
            if (any_req) begin
               grant_nxt = pick;
               state_nxt = XFER;
               cnt_nxt   = '0;
            end
         end
         XFER: begin
            req_ready = tx_full ? '0 : (NUM_REQ'(1) << gsel);
            tx_wr_en  = g_valid && !tx_full;
            if (tx_wr_en) begin
               tx_data = data_arr[gsel];
               if (g_last) begin
                  state_nxt = IDLE;
               end else begin
                  cnt_nxt = '0;
               end
            end else if (!tx_full) begin
               // Owner is starving; a full FIFO never advances the watchdog.
               if (WD_EN && (cnt == WD_LAST)) begin
                  tout_nxt  = 1'b1;
                  state_nxt = IDLE;
                  cnt_nxt   = '0;
               end else if (cnt != '1) begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: packet-level reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
// Honours UART_TX_ARB_PRIO_EN when defined for the build.
module tb_uart_tx_arb;

   localparam int N  = 3;
   localparam int TO = 4;

   logic           clk_tx = 1'b0;
   logic           rst_clk_tx_n;
   logic [N-1:0]   req_valid;
   logic [8*N-1:0] req_data;
   logic [N-1:0]   req_last;
   logic [N-1:0]   req_ready;
   logic           tx_full;
   logic [7:0]     tx_data;
   logic           tx_wr_en;
   logic [2:0]     grant_id;
   logic           busy;
   logic           timeout_err;

   uart_tx_arb #(
      .NUM_REQ     (N),
      .TIMEOUT_CYC (TO),
      .CNT_W       (16)
   ) dut (
      .clk_tx       (clk_tx),
      .rst_clk_tx_n (rst_clk_tx_n),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_last     (req_last),
      .req_ready    (req_ready),
      .tx_full      (tx_full),
      .tx_data      (tx_data),
      .tx_wr_en     (tx_wr_en),
      .grant_id     (grant_id),
      .busy         (busy),
      .timeout_err  (timeout_err)
   );

   always #5 clk_tx = ~clk_tx;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Per-requester packet streams: byte and last flag.
   logic [7:0] qd [N][$];
   bit         ql [N][$];
   bit         en [N];
   int         pct [N];
   bit         rand_mode = 1'b0;
   bit         full_v    = 1'b0;
   bit [N-1:0] acc       = '0;

   // Reference model: is a packet locked, to whom, and for how long has the owner starved.
   bit m_lock   = 1'b0;
   int m_owner  = N - 1;
   int m_starve = 0;
   bit m_tout   = 1'b0;

   // Observed FIFO writes and timeout pulses.
   int wr_g [$];
   int wr_d [$];
   int wr_c [$];
   int to_c [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Arbitration rule: first valid requester after the last grant, wrapping.
   function automatic int rr_pick(input int last, input logic [N-1:0] v);
      int c;
`ifdef UART_TX_ARB_PRIO_EN
      if (v[0]) return 0;
`endif
      for (int k = 1; k <= N; k++) begin
         c = (last + k) % N;
         if (v[c]) return c;
      end
      return last;
   endfunction

   // Compare process: all outputs against the model every falling edge, then advance it.
   initial begin
      logic [N-1:0] e_ready;
      logic         e_wr;
      logic [7:0]   e_data;
      int           o;
      forever begin
         @(negedge clk_tx);
         cyc++;
         if (!rst_clk_tx_n) begin
            m_lock = 1'b0; m_owner = N - 1; m_starve = 0; m_tout = 1'b0;
            acc = '0;
            chk("rst_busy", 32'(busy), 0);
            chk("rst_grant", 32'(grant_id), N - 1);
            chk("rst_ready", 32'(req_ready), 0);
            chk("rst_wr_en", 32'(tx_wr_en), 0);
            chk("rst_timeout", 32'(timeout_err), 0);
         end else begin
            o       = m_owner;
            e_ready = (m_lock && !tx_full) ? (N'(1) << o) : '0;
            e_wr    = m_lock && req_valid[o] && !tx_full;
            e_data  = e_wr ? req_data[8*o +: 8] : 8'h00;
            chk("busy", 32'(busy), 32'(m_lock));
            chk("grant_id", 32'(grant_id), o);
            chk("timeout_err", 32'(timeout_err), 32'(m_tout));
            chk("req_ready", 32'(req_ready), 32'(e_ready));
            chk("tx_wr_en", 32'(tx_wr_en), 32'(e_wr));
            chk("tx_data", 32'(tx_data), 32'(e_data));
            acc = e_ready & req_valid;
            if (tx_wr_en === 1'b1) begin
               wr_g.push_back(int'(grant_id));
               wr_d.push_back(int'(tx_data));
               wr_c.push_back(cyc);
            end
            if (timeout_err === 1'b1) to_c.push_back(cyc);
            m_tout = 1'b0;
            if (!m_lock) begin
               if (|req_valid) begin
                  m_owner  = rr_pick(m_owner, req_valid);
                  m_lock   = 1'b1;
                  m_starve = 0;
               end
            end else if (e_wr) begin
               if (req_last[o]) m_lock = 1'b0;
               else m_starve = 0;
            end else if (!tx_full) begin
               if (m_starve == TO - 1) begin
                  m_tout = 1'b1; m_lock = 1'b0; m_starve = 0;
               end else begin
                  m_starve++;
               end
            end
         end
      end
   end

   // Driver: retire accepted bytes, present queue heads, optionally randomize traffic.
   initial begin
      int dcyc = 0;
      int len;
      forever begin
         @(posedge clk_tx);
         #1;
         dcyc++;
         for (int i = 0; i < N; i++) begin
            if (acc[i] && qd[i].size() > 0) begin
               void'(qd[i].pop_front());
               void'(ql[i].pop_front());
            end
         end
         if (rand_mode) begin
            if (dcyc % 64 == 0) begin
               for (int i = 0; i < N; i++) begin
                  case ($urandom_range(0, 2))
                     0:       pct[i] = 20;
                     1:       pct[i] = 60;
                     default: pct[i] = 95;
                  endcase
               end
            end
            for (int i = 0; i < N; i++) begin
               if (qd[i].size() == 0) begin
                  len = $urandom_range(1, 4);
                  for (int b = 0; b < len; b++) begin
                     qd[i].push_back(8'($urandom));
                     ql[i].push_back(b == len - 1);
                  end
               end
               en[i] = ($urandom_range(0, 99) < pct[i]);
            end
            tx_full = ($urandom_range(0, 4) == 0);
         end else begin
            tx_full = full_v;
         end
         for (int i = 0; i < N; i++) begin
            req_valid[i]        = en[i] && (qd[i].size() > 0);
            req_data[8*i +: 8]  = (qd[i].size() > 0) ? qd[i][0] : 8'($urandom);
            req_last[i]         = (qd[i].size() > 0) ? ql[i][0] : 1'($urandom);
         end
      end
   end

   task automatic push(input int r, input logic [7:0] d, input bit l);
      qd[r].push_back(d);
      ql[r].push_back(l);
   endtask

   // Wait (bounded) until the write log holds at least target entries.
   task automatic wait_writes(input int target, input int budget, input string name);
      int n = 0;
      while (wr_d.size() < target && n < budget) begin
         @(posedge clk_tx); #2; n++;
      end
      checks++;
      if (wr_d.size() < target) begin
         failures++;
         $display("FAIL %s: %0d writes seen, %0d required", name, wr_d.size(), target);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk_tx);
      #2;
   endtask

   // Directed scenarios followed by randomized traffic.
   initial begin
      int base;
      int tb;
      int exp_g [6];
      rst_clk_tx_n = 1'b0;
      tx_full = 1'b0; req_valid = '0; req_data = '0; req_last = '0;
      for (int i = 0; i < N; i++) begin en[i] = 1'b0; pct[i] = 95; end
      step(3);
      chk("lit_reset_grant", 32'(grant_id), 2);
      chk("lit_reset_busy", 32'(busy), 0);
      rst_clk_tx_n = 1'b1;

      // Round robin after reset: grants 0,1,2,0, a write every second cycle.
      base = wr_d.size();
      push(0, 8'h10, 1); push(0, 8'h11, 1); push(1, 8'h20, 1); push(2, 8'h30, 1);
      for (int i = 0; i < N; i++) en[i] = 1'b1;
      wait_writes(base + 4, 40, "rr_writes");
      if (wr_d.size() >= base + 4) begin
         chk("rr_g0", wr_g[base], 0);   chk("rr_d0", wr_d[base], 8'h10);
         chk("rr_g1", wr_g[base+1], 1); chk("rr_d1", wr_d[base+1], 8'h20);
         chk("rr_g2", wr_g[base+2], 2); chk("rr_d2", wr_d[base+2], 8'h30);
         chk("rr_g3", wr_g[base+3], 0); chk("rr_d3", wr_d[base+3], 8'h11);
         for (int k = 1; k < 4; k++) chk("rr_spacing", wr_c[base+k] - wr_c[base+k-1], 2);
      end
      step(3);

      // Packet lock: req1's 4 bytes back to back, req0 only afterwards.
      base = wr_d.size();
      push(1, 8'h41, 0); push(1, 8'h42, 0); push(1, 8'h43, 0); push(1, 8'h44, 1);
      push(0, 8'h55, 1);
      wait_writes(base + 5, 40, "lock_writes");
      if (wr_d.size() >= base + 5) begin
         for (int k = 0; k < 4; k++) begin
            chk("lock_g", wr_g[base+k], 1);
            chk("lock_d", wr_d[base+k], 8'h41 + k);
            if (k > 0) chk("lock_contig", wr_c[base+k] - wr_c[base+k-1], 1);
         end
         chk("lock_after_g", wr_g[base+4], 0);
         chk("lock_after_d", wr_d[base+4], 8'h55);
      end
      step(3);

      // Backpressure: 10 full cycles mid-packet neither transfer nor trip the watchdog.
      base = wr_d.size();
      tb   = to_c.size();
      push(2, 8'h61, 0); push(2, 8'h62, 0); push(2, 8'h63, 1);
      wait_writes(base + 1, 20, "bp_first");
      full_v = 1'b1;
      step(3);
      chk("lit_bp_ready", 32'(req_ready), 0);
      chk("lit_bp_wr_en", 32'(tx_wr_en), 0);
      chk("lit_bp_busy", 32'(busy), 1);
      step(7);
      full_v = 1'b0;
      chk("bp_held_writes", wr_d.size(), base + 2);
      wait_writes(base + 3, 20, "bp_complete");
      if (wr_d.size() >= base + 3) begin
         chk("bp_g", wr_g[base+2], 2);
         chk("bp_d", wr_d[base+2], 8'h63);
      end
      chk("bp_no_timeout", to_c.size(), tb);
      step(3);

      // Watchdog: req2 stalls after one non-final byte; req0 takes over after release.
      base = wr_d.size();
      tb   = to_c.size();
      push(2, 8'h71, 0);
      wait_writes(base + 1, 20, "wd_first");
      push(0, 8'h81, 1);
      begin
         int n = 0;
         while (to_c.size() == tb && n < 30) begin step(1); n++; end
      end
      chk("wd_pulse_seen", 32'(to_c.size() > tb), 1);
      if (to_c.size() > tb && wr_c.size() > base) begin
         // Write sampled before its edge, pulse sampled after its edge: 4 edges apart.
         chk("wd_pulse_delay", to_c[tb] - wr_c[base], 5);
      end
      wait_writes(base + 2, 20, "wd_next");
      if (wr_d.size() >= base + 2) begin
         chk("wd_next_g", wr_g[base+1], 0);
         chk("wd_next_d", wr_d[base+1], 8'h81);
      end
      step(5);
      chk("wd_single_pulse", to_c.size(), tb + 1);

      // Two requesters streaming single-byte packets.
      base = wr_d.size();
      for (int k = 0; k < 3; k++) begin
         push(0, 8'hA0 + 8'(k), 1);
         push(1, 8'hB0 + 8'(k), 1);
      end
`ifdef UART_TX_ARB_PRIO_EN
      exp_g = '{0, 0, 0, 1, 1, 1};
`else
      exp_g = '{1, 0, 1, 0, 1, 0};
`endif
      wait_writes(base + 6, 60, "prio_writes");
      if (wr_d.size() >= base + 6) begin
         for (int k = 0; k < 6; k++) chk("prio_grant", wr_g[base+k], exp_g[k]);
      end
      step(3);

      // Reset in the middle of a 3-byte packet.
      base = wr_d.size();
      push(1, 8'h91, 0); push(1, 8'h92, 0); push(1, 8'h93, 1);
      wait_writes(base + 1, 20, "rst_first");
      rst_clk_tx_n = 1'b0;
      #1;
      chk("lit_rstmid_busy", 32'(busy), 0);
      chk("lit_rstmid_ready", 32'(req_ready), 0);
      chk("lit_rstmid_wr_en", 32'(tx_wr_en), 0);
      for (int i = 0; i < N; i++) begin qd[i].delete(); ql[i].delete(); end
      step(2);
      rst_clk_tx_n = 1'b1;
      base = wr_d.size();
      push(0, 8'hC0, 1); push(1, 8'hC1, 1);
      wait_writes(base + 1, 20, "rst_regrant");
      if (wr_d.size() >= base + 1) begin
         chk("rstmid_first_g", wr_g[base], 0);
         chk("rstmid_first_d", wr_d[base], 8'hC0);
      end
      step(5);

      // Randomized traffic, FIFO backpressure and stalls.
      rand_mode = 1'b1;
      step(3000);
      rand_mode = 1'b0;
      for (int i = 0; i < N; i++) en[i] = 1'b0;
      step(5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
